mem_ctrl: RTL



---
 rtl/mem_ctrl_pkg.sv | 27 ++
 rtl/mem_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared constants and types for the byte-serial memory controller
package mem_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [2:0] MEM_SIZE_B = 3'd1;
  localparam logic [2:0] MEM_SIZE_H = 3'd2;
  localparam logic [2:0] MEM_SIZE_W = 3'd4;

  typedef enum logic {
    OWNER_LS = 1'b0,
    OWNER_IF = 1'b1
  } owner_e;

  // Any size code other than byte/half is served as a full word.
  function automatic logic [2:0] size_to_len(input logic [2:0] size);
    case (size)
      MEM_SIZE_B: size_to_len = MEM_SIZE_B;
      MEM_SIZE_H: size_to_len = MEM_SIZE_H;
      default:    size_to_len = MEM_SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates LS/IF requests and serialises them onto a byte-wide RAM port
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  in_rollback,
  input  logic                  in_ls_ena,
  input  logic                  in_ls_iswrite,
  input  logic [ADDR_WIDTH-1:0] in_ls_addr,
  input  logic [DATA_WIDTH-1:0] in_ls_data,
  input  logic [2:0]            in_ls_size,
  output logic                  out_ls_ready,
  output logic [DATA_WIDTH-1:0] out_ls_data,
  input  logic                  in_if_ena,
  input  logic [ADDR_WIDTH-1:0] in_if_addr,
  output logic                  out_if_ready,
  output logic [DATA_WIDTH-1:0] out_if_data,
  input  logic [7:0]            in_ram_data,
  output logic [ADDR_WIDTH-1:0] out_ram_addr,
  output logic [7:0]            out_ram_data,
  output logic                  out_ram_wr
);

  // Byte i is issued at step i and captured RECV_LAG steps later.
  localparam logic [2:0] RECV_LAG = 3'(RAM_LATENCY + 1);
  localparam logic [2:0] DONE_LAG = 3'(RAM_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e                  r_state;
  state_e                  w_state_nxt;
  owner_e                  r_owner;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [2:0]              r_len;
  logic [2:0]              r_cnt;
  logic [DATA_WIDTH-1:0]   r_rbuf;
  logic                    r_stalled;
  logic [7:0]              r_snap;

  logic                    r_lq_valid;
  logic                    r_lq_write;
  logic [ADDR_WIDTH-1:0]   r_lq_addr;
  logic [DATA_WIDTH-1:0]   r_lq_data;
  logic [2:0]              r_lq_size;

  logic                    r_ls_ready;
  logic [DATA_WIDTH-1:0]   r_ls_data;
  logic                    r_if_ready;
  logic [DATA_WIDTH-1:0]   r_if_data;
  logic [ADDR_WIDTH-1:0]   r_ram_addr;
  logic [7:0]              r_ram_data;
  logic                    r_ram_wr;

  logic                    w_accept;
  logic                    w_accept_ls;
  logic                    w_step;
  logic                    w_done;
  logic                    w_hold;
  logic                    w_abort;
  logic                    w_ls_req;
  logic                    w_sel_write;
  logic                    w_sel_is_write;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic [2:0]              w_sel_len;
  logic [2:0]              w_j;
  logic                    w_issue;
  logic                    w_recv;
  logic                    w_capture;
  logic [1:0]              w_rx_idx;
  logic [1:0]              w_tx_idx;
  logic [7:0]              w_rx_byte;
  logic [7:0]              w_tx_byte;
  logic [DATA_WIDTH-1:0]   w_rbuf_ins;

  assign w_ls_req       = r_lq_valid | in_ls_ena;
  assign w_sel_write    = r_lq_valid ? r_lq_write : in_ls_iswrite;
  assign w_sel_is_write = w_ls_req & w_sel_write;
  assign w_sel_addr     = w_ls_req ? (r_lq_valid ? r_lq_addr : in_ls_addr) : in_if_addr;
  assign w_sel_data     = r_lq_valid ? r_lq_data : in_ls_data;
  assign w_sel_len      = w_ls_req ? size_to_len(r_lq_valid ? r_lq_size : in_ls_size)
                                   : MEM_SIZE_W;

  assign w_j       = r_cnt + 3'd1;
  assign w_issue   = w_step & (w_j < r_len);
  assign w_recv    = w_step & (r_state == S_READ) & (w_j >= RECV_LAG);
  assign w_rx_idx  = 2'(w_j - RECV_LAG);
  assign w_tx_idx  = 2'(w_j);
  // The byte that was on the RAM bus when a stall began is replayed from r_snap.
  assign w_rx_byte = r_stalled ? r_snap : in_ram_data;
  assign w_tx_byte = r_wdata[{w_tx_idx, 3'b000} +: 8];

  // A flushed load pulse is dropped; stores survive rollback.
  assign w_capture = in_ls_ena & ~(w_accept_ls & ~r_lq_valid) & ~(in_rollback & ~in_ls_iswrite);

  always_comb begin
    w_rbuf_ins = r_rbuf;
    w_rbuf_ins[{w_rx_idx, 3'b000} +: 8] = w_rx_byte;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = FALSE;
    w_accept_ls = FALSE;
    w_step      = FALSE;
    w_done      = FALSE;
    w_hold      = FALSE;
    w_abort     = FALSE;
    case (r_state)
      S_IDLE: begin
        if (!in_rollback && ena && (w_ls_req || in_if_ena)) begin
          w_accept    = TRUE;
          w_accept_ls = w_ls_req;
          w_state_nxt = w_sel_is_write ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        if (in_rollback) begin
          w_abort     = TRUE;
          w_state_nxt = S_IDLE;
        end else if (!ena) begin
          w_hold = TRUE;
        end else begin
          w_step = TRUE;
          if (w_j == r_len + DONE_LAG) begin
            w_done      = TRUE;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        if (!ena) begin
          w_hold = TRUE;
        end else begin
          w_step = TRUE;
          if (w_j == r_len) begin
            w_done      = TRUE;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= OWNER_LS;
      r_addr     <= '0;
      r_wdata    <= ZERO_DATA;
      r_len      <= '0;
      r_cnt      <= '0;
      r_rbuf     <= ZERO_DATA;
      r_stalled  <= FALSE;
      r_snap     <= '0;
      r_lq_valid <= FALSE;
      r_lq_write <= FALSE;
      r_lq_addr  <= '0;
      r_lq_data  <= ZERO_DATA;
      r_lq_size  <= '0;
      r_ls_ready <= FALSE;
      r_ls_data  <= ZERO_DATA;
      r_if_ready <= FALSE;
      r_if_data  <= ZERO_DATA;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_ram_wr   <= FALSE;
    end else begin
      r_ls_ready <= FALSE;
      r_if_ready <= FALSE;
      r_ram_wr   <= FALSE;

      if (w_accept_ls || (in_rollback && !r_lq_write)) r_lq_valid <= FALSE;
      if (w_capture) begin
        r_lq_valid <= TRUE;
        r_lq_write <= in_ls_iswrite;
        r_lq_addr  <= in_ls_addr;
        r_lq_data  <= in_ls_data;
        r_lq_size  <= in_ls_size;
      end

      if (w_accept) begin
        r_owner    <= w_ls_req ? OWNER_LS : OWNER_IF;
        r_addr     <= w_sel_addr;
        r_wdata    <= w_sel_data;
        r_len      <= w_sel_len;
        r_cnt      <= '0;
        r_rbuf     <= ZERO_DATA;
        r_stalled  <= FALSE;
        r_ram_addr <= w_sel_addr;
        if (w_sel_is_write) begin
          r_ram_data <= w_sel_data[7:0];
          r_ram_wr   <= TRUE;
        end
      end

      if (w_step) begin
        r_cnt     <= w_j;
        r_stalled <= FALSE;
        if (w_issue) begin
          r_ram_addr <= r_addr + ADDR_WIDTH'(w_j);
          if (r_state == S_WRITE) begin
            r_ram_data <= w_tx_byte;
            r_ram_wr   <= TRUE;
          end
        end
        if (w_recv) r_rbuf <= w_rbuf_ins;
        if (w_done) begin
          if (r_state == S_WRITE || r_owner == OWNER_LS) r_ls_ready <= TRUE;
          else                                           r_if_ready <= TRUE;
          if (r_state == S_READ) begin
            if (r_owner == OWNER_LS) r_ls_data <= w_rbuf_ins;
            else                     r_if_data <= w_rbuf_ins;
          end
        end
      end

      if (w_hold && !r_stalled) begin
        r_stalled <= TRUE;
        r_snap    <= in_ram_data;
      end
      if (w_abort) r_stalled <= FALSE;
    end
  end

  assign out_ls_ready = r_ls_ready;
  assign out_ls_data  = r_ls_data;
  assign out_if_ready = r_if_ready;
  assign out_if_data  = r_if_data;
  assign out_ram_addr = r_ram_addr;
  assign out_ram_data = r_ram_data;
  assign out_ram_wr   = r_ram_wr;

endmodule
